// File: rtl/vdp_super_res_pkg.sv
// Shared types and constants for the super-res prefetch path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vdp_super_res_pkg;

    // Prefetch FSM: idle, one read outstanding, or one read outstanding whose data is dropped
    typedef enum logic [1:0] {
        PF_IDLE  = 2'd0,
        PF_REQ   = 2'd1,
        PF_DRAIN = 2'd2
    } pf_state_t;

    // VRAM read port width in bytes; the address advances by this per word
    localparam int WORD_BYTES = 4;

    // Default read-ahead depth in words
    localparam int PF_DEFAULT_DEPTH = 4;

endpackage

// File: rtl/vdp_sync_fifo.sv
// Generic synchronous FIFO with a registered head word (0 when empty) and occupancy count.
// Latency: a push into an empty FIFO is visible on head one cycle later.
// Backpressure: none internally; pushes while full are dropped, pops while empty are ignored.
module vdp_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             not_empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [LW-1:0]    count;
    logic             pop_eff;
    logic             push_eff;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [LW-1:0]    count_nxt;
    logic [WIDTH-1:0] head_nxt;

    // Effective push/pop and the head word as it will look after this cycle
    always_comb begin
        pop_eff    = pop && (count != '0);
        push_eff   = push && ((count != LW'(DEPTH)) || pop_eff);
        rd_ptr_nxt = rd_ptr + AW'(pop_eff);
        count_nxt  = count + LW'(push_eff) - LW'(pop_eff);
        head_nxt   = '0;
        if (count_nxt == '0) begin
            head_nxt = '0;
        end else if (push_eff && ((count - LW'(pop_eff)) == '0)) begin
            // Only the incoming word will be stored: it becomes the head directly
            head_nxt = push_data;
        end else begin
            head_nxt = mem[rd_ptr_nxt];
        end
    end

    // Storage array; contents are don't-care until counted, so no reset
    always_ff @(posedge clk) begin
        if (push_eff && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, count and registered head; flush beats a same-cycle push
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            rd_ptr <= rd_ptr_nxt;
            wr_ptr <= wr_ptr + AW'(push_eff);
            count  <= count_nxt;
            head   <= head_nxt;
        end
    end

    assign not_empty = (count != '0);
    assign level     = count;

endmodule

// File: rtl/vdp_super_res_prefetch.sv
// Read-ahead of sequential 32-bit VRAM words into a small FIFO for the super-res pixel fetcher.
// Latency: request one cycle after issue is sampled; acked word on data_out the next cycle if empty.
// Backpressure: issues a read only when a FIFO slot is guaranteed; mem_req held until mem_ack.
// Optional: define VDP_PREFETCH_UNDERRUN_EN for the underrun / underrun_count outputs.
module vdp_super_res_prefetch
    import vdp_super_res_pkg::*;
#(
    parameter int DEPTH  = PF_DEFAULT_DEPTH,
    parameter int ADDR_W = 17
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    frame_start,
    input  logic                    fetch_en,
    output logic                    mem_req,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic                    mem_ack,
    input  logic [31:0]             mem_data,
    input  logic                    pop,
    output logic [31:0]             data_out,
    output logic                    data_valid,
    output logic [$clog2(DEPTH):0]  level
`ifdef VDP_PREFETCH_UNDERRUN_EN
    ,
    output logic                    underrun,
    output logic [15:0]             underrun_count
`endif
);

    localparam int LW  = $clog2(DEPTH) + 1;
    localparam int LW1 = LW + 1;

    pf_state_t         state_q;
    pf_state_t         state_d;
    logic              flush;
    logic              pop_eff;
    logic              push;
    logic [LW1-1:0]    lvl_after;
    logic              issue_now;
    logic              issue_after_push;
    logic [ADDR_W-1:0] addr_d;

    // Occupancy after this cycle's pop (or flush) and the two issue conditions
    always_comb begin
        flush            = frame_start | ~enable;
        pop_eff          = pop && (level != '0);
        lvl_after        = flush ? '0 : ({1'b0, level} - LW1'(pop_eff));
        issue_now        = enable && fetch_en && (lvl_after < LW1'(DEPTH));
        issue_after_push = enable && fetch_en && ((lvl_after + LW1'(1)) < LW1'(DEPTH));
    end

    // Next state and push decision; a flushed outstanding read is drained, never withdrawn
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            PF_IDLE: begin
                if (issue_now) state_d = PF_REQ;
            end
            PF_REQ: begin
                if (mem_ack) begin
                    if (flush) begin
                        state_d = issue_now ? PF_REQ : PF_IDLE;
                    end else begin
                        push    = 1'b1;
                        state_d = issue_after_push ? PF_REQ : PF_IDLE;
                    end
                end else if (flush) begin
                    state_d = PF_DRAIN;
                end
            end
            PF_DRAIN: begin
                if (mem_ack) state_d = issue_now ? PF_REQ : PF_IDLE;
            end
            default: state_d = PF_IDLE;
        endcase
    end

    // Next address: held while a drained read is outstanding, rewound once a flush can land
    always_comb begin
        addr_d = mem_addr;
        if (state_d == PF_DRAIN) begin
            addr_d = mem_addr;
        end else if (flush || (state_q == PF_DRAIN)) begin
            addr_d = '0;
        end else if (push) begin
            addr_d = mem_addr + ADDR_W'(WORD_BYTES);
        end
    end

    // State and address registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= PF_IDLE;
            mem_addr <= '0;
        end else begin
            state_q  <= state_d;
            mem_addr <= addr_d;
        end
    end

    assign mem_req = (state_q != PF_IDLE);

    vdp_sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .push_data (mem_data),
        .pop       (pop),
        .head      (data_out),
        .not_empty (data_valid),
        .level     (level)
    );

`ifdef VDP_PREFETCH_UNDERRUN_EN
    // Sticky underrun flag and saturating event count, both cleared at frame start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else if (frame_start) begin
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else if (pop && enable && (level == '0)) begin
            underrun <= 1'b1;
            if (underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vdp_super_res_prefetch.sv
// Directed bench for the super-res prefetch stage with a latency-programmable VRAM responder.
// Latency: n/a.
// Backpressure: n/a.
module tb_vdp_super_res_prefetch;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 17;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              frame_start;
    logic              fetch_en;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_data;
    logic              pop;
    logic [31:0]       data_out;
    logic              data_valid;
    logic [LW-1:0]     level;
`ifdef VDP_PREFETCH_UNDERRUN_EN
    logic              underrun;
    logic [15:0]       underrun_count;
`endif

    logic              resp_en   = 1'b0;
    int                ack_lat   = 2;
    int                resp_wait = 0;
    logic              resp_ack  = 1'b0;
    logic [31:0]       resp_data = '0;
    logic              man_ack   = 1'b0;
    logic [31:0]       man_data  = '0;
    logic [ADDR_W-1:0] acked_q[$];

    int n_assert = 0;
    int n_fail   = 0;

    assign mem_ack  = resp_ack | man_ack;
    assign mem_data = man_ack ? man_data : resp_data;

    always #5 clk = ~clk;

    vdp_super_res_prefetch #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .frame_start    (frame_start),
        .fetch_en       (fetch_en),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_data       (mem_data),
        .pop            (pop),
        .data_out       (data_out),
        .data_valid     (data_valid),
        .level          (level)
`ifdef VDP_PREFETCH_UNDERRUN_EN
        ,
        .underrun       (underrun),
        .underrun_count (underrun_count)
`endif
    );

    // Memory contents: each word carries its own byte address
    function automatic logic [31:0] mdata(input logic [ADDR_W-1:0] a);
        return 32'hD000_0000 | {15'b0, a};
    endfunction

    // Responder: acks the outstanding request ack_lat cycles after first seeing it
    always @(posedge clk) begin
        #1;
        resp_ack = 1'b0;
        if (!resp_en || !reset || !mem_req) begin
            resp_wait = 0;
        end else if (resp_wait >= ack_lat) begin
            resp_ack  = 1'b1;
            resp_data = mdata(mem_addr);
            acked_q.push_back(mem_addr);
            resp_wait = 0;
        end else begin
            resp_wait++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n cycles, sampling 1 time unit after each edge; a full FIFO must never have a read open
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("no_req_when_full", 32'((level == LW'(DEPTH)) && mem_req), 32'd0);
        end
    endtask

    initial begin
        int cyc;
        int q_base;
        logic found;

        reset = 1'b0; enable = 1'b0; frame_start = 1'b0; fetch_en = 1'b0; pop = 1'b0;
        tick(3);
        chk("rst_mem_req",  32'(mem_req),    32'd0);
        chk("rst_mem_addr", 32'(mem_addr),   32'd0);
        chk("rst_data_out", data_out,        32'd0);
        chk("rst_valid",    32'(data_valid), 32'd0);
        chk("rst_level",    32'(level),      32'd0);

        // Pop on empty after reset
        reset = 1'b1;
        tick(1);
        enable = 1'b1; pop = 1'b1;
        tick(1);
        pop = 1'b0;
        chk("empty_pop_data",  data_out,        32'd0);
        chk("empty_pop_level", 32'(level),      32'd0);
        chk("empty_pop_valid", 32'(data_valid), 32'd0);
`ifdef VDP_PREFETCH_UNDERRUN_EN
        chk("underrun_set",   32'(underrun),       32'd1);
        chk("underrun_cnt1",  32'(underrun_count), 32'd1);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        chk("underrun_clr",   32'(underrun),       32'd0);
        chk("underrun_cnt0",  32'(underrun_count), 32'd0);
`endif

        // Initial fill, ack latency 2, no pops
        resp_en = 1'b1; ack_lat = 2; q_base = acked_q.size(); fetch_en = 1'b1;
        tick(1);
        chk("first_req",       32'(mem_req),    32'd1);
        chk("first_addr",      32'(mem_addr),   32'd0);
        chk("first_valid_pre", 32'(data_valid), 32'd0);
        tick(3);
        chk("first_valid",     32'(data_valid), 32'd1);
        chk("first_data",      data_out,        32'hD000_0000);
        chk("first_level",     32'(level),      32'd1);
        chk("second_addr",     32'(mem_addr),   32'd4);
        cyc = 0;
        while (!((level == LW'(4)) && !mem_req) && (cyc < 60)) begin tick(1); cyc++; end
        chk("fill_timeout", 32'(cyc < 60), 32'd1);
        chk("fill_level",   32'(level),      32'd4);
        chk("fill_req",     32'(mem_req),    32'd0);
        chk("fill_next",    32'(mem_addr),   32'h10);
        chk("fill_head",    data_out,        32'hD000_0000);
        chk("fill_valid",   32'(data_valid), 32'd1);
        chk("fill_nacks",   32'(acked_q.size() - q_base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (q_base + i < acked_q.size()) chk("fill_ack_addr", 32'(acked_q[q_base + i]), 32'(4 * i));
        end

        // frame_start while a read at 0x10 is outstanding
        resp_en = 1'b0;
        pop = 1'b1;
        tick(1);
        pop = 1'b0;
        chk("req10_req",   32'(mem_req),  32'd1);
        chk("req10_addr",  32'(mem_addr), 32'h10);
        chk("req10_level", 32'(level),    32'd3);
        chk("req10_head",  data_out,      32'hD000_0004);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        chk("drain_req",   32'(mem_req),    32'd1);
        chk("drain_addr",  32'(mem_addr),   32'h10);
        chk("drain_level", 32'(level),      32'd0);
        chk("drain_data",  data_out,        32'd0);
        chk("drain_valid", 32'(data_valid), 32'd0);
        tick(2);
        chk("drain_hold_req",  32'(mem_req),  32'd1);
        chk("drain_hold_addr", 32'(mem_addr), 32'h10);
        man_data = 32'hDEAD_BEEF; man_ack = 1'b1;
        tick(1);
        man_ack = 1'b0;
        chk("rewind_req",   32'(mem_req),    32'd1);
        chk("rewind_addr",  32'(mem_addr),   32'd0);
        chk("rewind_level", 32'(level),      32'd0);
        chk("rewind_valid", 32'(data_valid), 32'd0);

        // Refill from address 0; the dropped word must not appear
        resp_en = 1'b1;
        cyc = 0;
        while (!((level == LW'(4)) && !mem_req) && (cyc < 60)) begin tick(1); cyc++; end
        chk("refill_timeout", 32'(cyc < 60), 32'd1);
        chk("refill_head",    data_out,      32'hD000_0000);
        chk("refill_next",    32'(mem_addr), 32'h10);

        // Steady state: one pop every 4 clocks, ack latency 2
        q_base = acked_q.size();
        for (int k = 0; k < 24; k++) begin
            chk("stream_data",  data_out,        mdata(ADDR_W'(4 * k)));
            chk("stream_valid", 32'(data_valid), 32'd1);
            pop = 1'b1;
            tick(1);
            pop = 1'b0;
            chk("stream_level", 32'((level >= LW'(3)) && (level <= LW'(4))), 32'd1);
            for (int j = 0; j < 3; j++) begin
                tick(1);
                chk("stream_level", 32'((level >= LW'(3)) && (level <= LW'(4))), 32'd1);
            end
        end
        chk("stream_nacks", 32'(acked_q.size() - q_base), 32'd24);
        for (int i = 0; i < 24; i++) begin
            if (q_base + i < acked_q.size()) chk("stream_ack_addr", 32'(acked_q[q_base + i]), 32'(16 + 4 * i));
        end

        // enable low flushes; frame_start while disabled changes nothing
        enable = 1'b0;
        tick(1);
        chk("dis_level", 32'(level),      32'd0);
        chk("dis_valid", 32'(data_valid), 32'd0);
        chk("dis_data",  data_out,        32'd0);
        chk("dis_req",   32'(mem_req),    32'd0);
        chk("dis_addr",  32'(mem_addr),   32'd0);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(1);
        chk("dis_fs_level", 32'(level),   32'd0);
        chk("dis_fs_req",   32'(mem_req), 32'd0);

        // Address wrap: one word per cycle with zero-latency acks and continuous pops
        ack_lat = 0; enable = 1'b1; pop = 1'b1;
        found = 1'b0; cyc = 0;
        while (!found && (cyc < 40000)) begin
            tick(1);
            cyc++;
            if (mem_req && (mem_addr == 17'h1FFFC)) found = 1'b1;
        end
        chk("wrap_reached", 32'(found), 32'd1);
        tick(1);
        chk("wrap_addr", 32'(mem_addr), 32'd0);
        chk("wrap_req",  32'(mem_req),  32'd1);

        // Reset in the middle of an outstanding read
        pop = 1'b0; resp_en = 1'b0;
        tick(2);
        chk("pre_reset_req", 32'(mem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_req",   32'(mem_req),    32'd0);
        chk("mid_rst_addr",  32'(mem_addr),   32'd0);
        chk("mid_rst_data",  data_out,        32'd0);
        chk("mid_rst_valid", 32'(data_valid), 32'd0);
        chk("mid_rst_level", 32'(level),      32'd0);
        tick(1);
        fetch_en = 1'b0; enable = 1'b1; reset = 1'b1;
        tick(1);
        man_data = 32'h1234_5678; man_ack = 1'b1;
        tick(1);
        man_ack = 1'b0;
        chk("stale_level", 32'(level),      32'd0);
        chk("stale_valid", 32'(data_valid), 32'd0);
        chk("stale_data",  data_out,        32'd0);
        chk("stale_req",   32'(mem_req),    32'd0);
        chk("stale_addr",  32'(mem_addr),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
